// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU state encodings and index/count width helpers
package alu_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_SCAN = SCAN,
    S_DONE = DONE
  } state_e;
  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/eq_vector_scanner_if.sv
// eq_vector_scanner_if: request/result bundle between the ALU and the scanner
interface eq_vector_scanner_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int IDXW  = idx_w(WIDTH),
  parameter int CNTW  = cnt_w(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] eq_in;
  logic             busy;
  logic             done;
  logic             all_eq;
  logic [IDXW-1:0]  first_diff;
  logic [CNTW-1:0]  match_count;
  modport master (output start, eq_in, input busy, done, all_eq, first_diff, match_count);
  modport slave  (input start, eq_in, output busy, done, all_eq, first_diff, match_count);
endinterface

// File: rtl/eq_vector_scanner.sv
// eq_vector_scanner: MSB-first serial walk of an equality vector yielding equality, top mismatch index and match count
module eq_vector_scanner
  import alu_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int IDXW  = idx_w(WIDTH),
  parameter int CNTW  = cnt_w(WIDTH)
) (
  input logic               clk,
  input logic               reset,
  eq_vector_scanner_if.slave bus
);
  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  pos_q;
  logic [CNTW-1:0]  acc_q;
  logic             seen_q;
  logic             busy_q;
  logic             done_q;
  logic             all_eq_q;
  logic [IDXW-1:0]  first_diff_q;
  logic [CNTW-1:0]  match_count_q;
  logic             accept;
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  // Capture is applied after the state case so a start in DONE overrides the return to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sh_q          <= '0;
      idx_q         <= '0;
      pos_q         <= '0;
      acc_q         <= '0;
      seen_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      all_eq_q      <= 1'b0;
      first_diff_q  <= '0;
      match_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (sh_q[WIDTH-1]) acc_q <= acc_q + CNTW'(1);
          else if (!seen_q) begin
            pos_q  <= idx_q;
            seen_q <= 1'b1;
          end
          sh_q  <= sh_q << 1;
          idx_q <= idx_q - IDXW'(1);
          if (idx_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          done_q        <= 1'b1;
          all_eq_q      <= !seen_q;
          first_diff_q  <= pos_q;
          match_count_q <= acc_q;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (accept) begin
        sh_q    <= bus.eq_in;
        idx_q   <= IDXW'(WIDTH - 1);
        pos_q   <= '0;
        acc_q   <= '0;
        seen_q  <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= S_SCAN;
      end
    end
  end
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.all_eq      = all_eq_q;
  assign bus.first_diff  = first_diff_q;
  assign bus.match_count = match_count_q;
endmodule

// File: tb/tb_eq_vector_scanner.sv
// tb_eq_vector_scanner: scoreboard bench for the serial equality scanner (WIDTH = 5)
module tb_eq_vector_scanner;
  typedef struct packed {
    logic       aeq;
    logic [2:0] fd;
    logic [2:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  exp_t sb[$];
  eq_vector_scanner_if #(.WIDTH(5)) bus ();
  eq_vector_scanner #(.WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [4:0] v);
    exp_t e;
    e.aeq = &v;
    e.fd  = '0;
    e.cnt = '0;
    for (int i = 0; i < 5; i++) begin
      e.cnt = e.cnt + {2'b0, v[i]};
      if (!v[i]) e.fd = 3'(i);
    end
    return e;
  endfunction
  task automatic test_reset();
    exp_t got;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.eq_in = 5'b11111;
    repeat (3) @(negedge clk);
    got = {bus.all_eq, bus.first_diff, bus.match_count};
    total++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_ctl busy/done=%b required 00", {bus.busy, bus.done});
    else passed++;
    total++;
    if (got !== '0) $display("FAIL reset_out got=%h required 0", got);
    else passed++;
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_scan(input string name, input logic [4:0] v, input exp_t e);
    int n;
    exp_t got, want;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.eq_in = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.eq_in = ~v;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL %s_busy got=%b required 1", name, bus.busy);
    else passed++;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 6) $display("FAIL %s_latency got=%0d required 6", name, n);
    else passed++;
    if (bus.done === 1'b1) begin
      want = sb.pop_front();
      got = {bus.all_eq, bus.first_diff, bus.match_count};
      total++;
      if (got !== want) $display("FAIL %s_result got aeq=%b fd=%0d cnt=%0d required aeq=%b fd=%0d cnt=%0d",
                                 name, got.aeq, got.fd, got.cnt, want.aeq, want.fd, want.cnt);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0) $display("FAIL %s_pulse got=%b required 0", name, bus.done);
    else passed++;
  endtask
  task automatic test_patterns();
    test_scan("all_eq", 5'b11111, '{aeq: 1'b1, fd: 3'd0, cnt: 3'd5});
    test_scan("bit3", 5'b10111, '{aeq: 1'b0, fd: 3'd3, cnt: 3'd4});
    test_scan("none", 5'b00000, '{aeq: 1'b0, fd: 3'd4, cnt: 3'd0});
    test_scan("bit0", 5'b11110, '{aeq: 1'b0, fd: 3'd0, cnt: 3'd4});
    for (int k = 0; k < 4; k++) begin
      logic [4:0] v;
      v = 5'($urandom_range(0, 31));
      test_scan("rand", v, model(v));
    end
  endtask
  task automatic test_back_to_back();
    int dones = 0;
    int at[2] = '{0, 0};
    exp_t got, want;
    sb.push_back('{aeq: 1'b0, fd: 3'd0, cnt: 3'd4});
    sb.push_back('{aeq: 1'b0, fd: 3'd4, cnt: 3'd4});
    @(negedge clk);
    bus.start = 1'b1;
    bus.eq_in = 5'b11110;
    @(negedge clk);
    bus.eq_in = 5'b01111;
    for (int n = 0; n <= 20; n++) begin
      if (bus.done === 1'b1) begin
        if (dones < 2) at[dones] = n;
        dones++;
        want = (sb.size() > 0) ? sb.pop_front() : '1;
        got = {bus.all_eq, bus.first_diff, bus.match_count};
        total++;
        if (got !== want) $display("FAIL b2b_result%0d got aeq=%b fd=%0d cnt=%0d required aeq=%b fd=%0d cnt=%0d",
                                   dones, got.aeq, got.fd, got.cnt, want.aeq, want.fd, want.cnt);
        else passed++;
      end
      bus.start = (n < 6) || (n == 9);
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (dones !== 2) $display("FAIL b2b_count got=%0d required 2", dones);
    else passed++;
    total++;
    if (at[0] !== 6 || at[1] !== 12) $display("FAIL b2b_timing got=%0d,%0d required 6,12", at[0], at[1]);
    else passed++;
  endtask
  task automatic test_reset_mid_scan();
    int dones = 0;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.eq_in = 5'b10101;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got = {bus.all_eq, bus.first_diff, bus.match_count};
    total++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL abort_ctl busy/done=%b required 00", {bus.busy, bus.done});
    else passed++;
    total++;
    if (got !== '0) $display("FAIL abort_out got=%h required 0", got);
    else passed++;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    total++;
    if (dones !== 0 || bus.busy !== 1'b0) $display("FAIL abort_quiet dones=%0d busy=%b required 0 0", dones, bus.busy);
    else passed++;
    test_scan("after_abort", 5'b10101, '{aeq: 1'b0, fd: 3'd3, cnt: 3'd3});
  endtask
  initial begin
    bus.start = 1'b0;
    bus.eq_in = '0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid_scan();
    total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_left got=%0d required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
